pacman_motion: RTL and testbench

- Downstream stage of the direction-decision logic.
- Consumes the registered 3-bit direction and advances Pac-Man's pixel position once per frame tick.
- On every tile-aligned position, reads the four neighbouring tiles from the synchronous maze wall ROM and rebuilds adjacent_walls.
- Closes the loop: pacman_x, pacman_y and adjacent_walls feed back into direction selection.

---
 rtl/pacman_pkg.sv | 35 +++
 rtl/maze_neighbor_addr.sv | 60 ++++++
 rtl/pacman_motion.sv | 153 +++++++++++++++
 tb/tb_pacman_motion.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pacman_pkg.sv
// pacman_pkg -- shared encodings for the Pac-Man motion stage.
//   dir_t          : 3-bit direction code (bit 2 = move request, bits 1:0 = wall bit index)
//   TILE_SHIFT     : pixel -> tile shift (16 px tiles)
//   WALL_*         : bit positions inside adjacent_walls
//   motion_state_t : FSM state type with its state constants
package pacman_pkg;

    localparam int TILE_SHIFT = 4;

    typedef enum logic [2:0] {
        DIR_STOP  = 3'b000,
        DIR_UP    = 3'b100,
        DIR_RIGHT = 3'b101,
        DIR_DOWN  = 3'b110,
        DIR_LEFT  = 3'b111
    } dir_t;

    // The low two bits of a moving direction code double as its wall bit index.
    localparam logic [1:0] WALL_UP    = 2'd0;
    localparam logic [1:0] WALL_RIGHT = 2'd1;
    localparam logic [1:0] WALL_DOWN  = 2'd2;
    localparam logic [1:0] WALL_LEFT  = 2'd3;

    typedef logic [1:0] motion_state_t;
    localparam motion_state_t ST_INIT   = 2'd0;
    localparam motion_state_t ST_IDLE   = 2'd1;
    localparam motion_state_t ST_LOOKUP = 2'd2;
    localparam motion_state_t ST_DRAIN  = 2'd3;

    // Codes without bit 2 set (stop and the unused codes) never move.
    function automatic logic dir_moves(input logic [2:0] d);
        return d[2];
    endfunction

endpackage

// File: rtl/maze_neighbor_addr.sv
// maze_neighbor_addr -- combinational neighbour-tile address generator.
//   tile_x, tile_y : current tile coordinates
//   idx            : neighbour index 0 up, 1 right, 2 down, 3 left
//   addr           : {ny, nx} ROM address of the neighbour (always produced)
//   force_wall     : neighbour lies outside the maze; treat as wall, ignore ROM
// Optional macro PACMAN_TUNNEL_EN: horizontal edges wrap to the opposite
// column instead of being forced walls.
module maze_neighbor_addr
    import pacman_pkg::*;
#(
    parameter int MAZE_W = 28,
    parameter int MAZE_H = 31
) (
    input  logic [4:0] tile_x,
    input  logic [4:0] tile_y,
    input  logic [1:0] idx,
    output logic [9:0] addr,
    output logic       force_wall
);

    localparam logic [4:0] LAST_X = 5'(MAZE_W - 1);
    localparam logic [4:0] LAST_Y = 5'(MAZE_H - 1);

    logic [4:0] nx;
    logic [4:0] ny;

    always_comb begin
        nx         = tile_x;
        ny         = tile_y;
        force_wall = 1'b0;
        case (idx)
            WALL_UP: begin
                ny         = tile_y - 5'd1;
                force_wall = (tile_y == 5'd0);
            end
            WALL_RIGHT: begin
`ifdef PACMAN_TUNNEL_EN
                nx = (tile_x == LAST_X) ? 5'd0 : tile_x + 5'd1;
`else
                nx         = tile_x + 5'd1;
                force_wall = (tile_x == LAST_X);
`endif
            end
            WALL_DOWN: begin
                ny         = tile_y + 5'd1;
                force_wall = (tile_y == LAST_Y);
            end
            default: begin
`ifdef PACMAN_TUNNEL_EN
                nx = (tile_x == 5'd0) ? LAST_X : tile_x - 5'd1;
`else
                nx         = tile_x - 5'd1;
                force_wall = (tile_x == 5'd0);
`endif
            end
        endcase
        addr = {ny, nx};
    end

endmodule

// File: rtl/pacman_motion.sv
// pacman_motion -- advances Pac-Man one STEP per frame tick and refreshes the
// four neighbouring wall bits from the synchronous maze ROM whenever the
// position lands on a tile boundary.
//   Clk, Reset_n   : clock, asynchronous active-low reset
//   frame_tick     : one-cycle pulse per frame
//   direction      : 000 stop, 100 up, 101 right, 110 down, 111 left
//   wall_rd        : ROM read strobe (high for the 4 lookup cycles)
//   wall_addr      : {tile_y, tile_x} of the neighbour being read
//   wall_data      : ROM data, valid the cycle after wall_rd (1 = wall)
//   pacman_x/y     : pixel position
//   adjacent_walls : bit0 up, bit1 right, bit2 down, bit3 left (1 = blocked)
//   walls_valid    : adjacent_walls belongs to the current aligned tile
// Optional macro PACMAN_TUNNEL_EN: horizontal wrap-around at the maze edges.
module pacman_motion
    import pacman_pkg::*;
#(
    parameter logic [9:0] START_X = 10'd216,
    parameter logic [9:0] START_Y = 10'd368,
    parameter int          MAZE_W  = 28,
    parameter int          MAZE_H  = 31,
    parameter int          STEP    = 1
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_tick,
    input  logic [2:0] direction,
    output logic       wall_rd,
    output logic [9:0] wall_addr,
    input  logic       wall_data,
    output logic [9:0] pacman_x,
    output logic [9:0] pacman_y,
    output logic [3:0] adjacent_walls,
    output logic       walls_valid
);

    localparam logic [9:0] STEP_PX = 10'(STEP);
`ifdef PACMAN_TUNNEL_EN
    localparam logic [9:0] EDGE_X  = 10'((MAZE_W - 1) * 16);
`endif

    motion_state_t state;
    logic [1:0]    idx;
    logic [2:0]    shadow;   // walls for idx 0..2; idx 3 arrives in DRAIN
    logic          force_q;  // force_wall of the read whose data is arriving now
    logic          pending;

    logic [4:0] tile_x;
    logic [4:0] tile_y;
    logic [9:0] nbr_addr;
    logic       nbr_force;

    assign tile_x = 5'(pacman_x >> TILE_SHIFT);
    assign tile_y = 5'(pacman_y >> TILE_SHIFT);

    maze_neighbor_addr #(
        .MAZE_W (MAZE_W),
        .MAZE_H (MAZE_H)
    ) u_nbr (
        .tile_x     (tile_x),
        .tile_y     (tile_y),
        .idx        (idx),
        .addr       (nbr_addr),
        .force_wall (nbr_force)
    );

    assign wall_rd   = (state == ST_LOOKUP);
    assign wall_addr = wall_rd ? nbr_addr : 10'd0;

    // Move decision for the IDLE state.
    logic       tick_eff;
    logic       aligned;
    logic       blocked;
    logic [9:0] next_x;
    logic [9:0] next_y;
    logic       next_aligned;

    assign tick_eff = frame_tick | pending;
    assign aligned  = (pacman_x[3:0] == 4'd0) && (pacman_y[3:0] == 4'd0);
    // Off-grid positions never consult the wall bits: the walls only describe
    // the tile Pac-Man last aligned on.
    assign blocked  = !dir_moves(direction) ||
                      (aligned && adjacent_walls[direction[1:0]]);

    always_comb begin
        next_x = pacman_x;
        next_y = pacman_y;
        case (direction)
            DIR_UP:    next_y = pacman_y - STEP_PX;
            DIR_DOWN:  next_y = pacman_y + STEP_PX;
`ifdef PACMAN_TUNNEL_EN
            DIR_RIGHT: next_x = (pacman_x == EDGE_X) ? 10'd0 : pacman_x + STEP_PX;
            DIR_LEFT:  next_x = (pacman_x == 10'd0) ? EDGE_X : pacman_x - STEP_PX;
`else
            DIR_RIGHT: next_x = pacman_x + STEP_PX;
            DIR_LEFT:  next_x = pacman_x - STEP_PX;
`endif
            default: ;
        endcase
    end

    assign next_aligned = (next_x[3:0] == 4'd0) && (next_y[3:0] == 4'd0);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state          <= ST_INIT;
            idx            <= 2'd0;
            shadow         <= 3'd0;
            force_q        <= 1'b0;
            pending        <= 1'b0;
            pacman_x       <= START_X;
            pacman_y       <= START_Y;
            adjacent_walls <= 4'd0;
            walls_valid    <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    pending <= pending | frame_tick;
                    idx     <= 2'd0;
                    state   <= ST_LOOKUP;
                end
                ST_IDLE: begin
                    pending <= 1'b0;
                    if (tick_eff && !blocked) begin
                        pacman_x <= next_x;
                        pacman_y <= next_y;
                        if (next_aligned) begin
                            walls_valid <= 1'b0;
                            idx         <= 2'd0;
                            state       <= ST_LOOKUP;
                        end
                    end
                end
                ST_LOOKUP: begin
                    pending <= pending | frame_tick;
                    force_q <= nbr_force;
                    // ROM answers one cycle late: this cycle carries idx-1.
                    if (idx != 2'd0)
                        shadow[idx - 2'd1] <= force_q | wall_data;
                    idx <= idx + 2'd1;
                    if (idx == 2'd3)
                        state <= ST_DRAIN;
                end
                default: begin // ST_DRAIN
                    pending        <= pending | frame_tick;
                    adjacent_walls <= {force_q | wall_data, shadow};
                    walls_valid    <= 1'b1;
                    state          <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pacman_motion.sv
// tb_pacman_motion -- randomized scoreboard bench for pacman_motion.
// The driver advances a frame-level reference model each clock and queues the
// expected outputs; an independent monitor pops and compares at each negedge.
// Also follows PACMAN_TUNNEL_EN so both builds are checked.
module tb_pacman_motion;

    localparam int W  = 28;
    localparam int H  = 31;
    localparam int ST = 1;
    localparam int SX = 216;
    localparam int SY = 368;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic [2:0] direction = 3'd0;
    logic       wall_rd;
    logic [9:0] wall_addr;
    logic       wall_data = 1'b0;
    logic [9:0] pacman_x;
    logic [9:0] pacman_y;
    logic [3:0] adjacent_walls;
    logic       walls_valid;

    always #5 Clk = ~Clk;

    pacman_motion #(
        .START_X (10'(SX)),
        .START_Y (10'(SY)),
        .MAZE_W  (W),
        .MAZE_H  (H),
        .STEP    (ST)
    ) dut (
        .Clk            (Clk),
        .Reset_n        (Reset_n),
        .frame_tick     (frame_tick),
        .direction      (direction),
        .wall_rd        (wall_rd),
        .wall_addr      (wall_addr),
        .wall_data      (wall_data),
        .pacman_x       (pacman_x),
        .pacman_y       (pacman_y),
        .adjacent_walls (adjacent_walls),
        .walls_valid    (walls_valid)
    );

    // Maze ROM; tiles outside the maze read as open so forced walls must come
    // from the design itself.
    bit maze [0:31][0:31];
    always @(posedge Clk)
        if (wall_rd)
            wall_data <= (int'(wall_addr[9:5]) < H && int'(wall_addr[4:0]) < W) ?
                         maze[wall_addr[9:5]][wall_addr[4:0]] : 1'b0;

    typedef struct {
        int x;
        int y;
        int walls;
        bit valid;
        bit rd;
    } exp_t;

    exp_t exp_q[$];
    int   addr_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    bit   mon_en = 1'b0;

    // ---------------- reference model ----------------
    int mx, my, mwalls, lkwalls, busy;  // busy = clock edges left before back in IDLE
    bit mvalid, pend, rst_done;

    // Neighbour of tile (tx,ty) in direction d: d 0 up, 1 right, 2 down, 3 left.
    task automatic neighbour(input int tx, input int ty, input int d,
                             output int nx, output int ny, output bit oob);
        nx  = tx + ((d == 1) ? 1 : (d == 3) ? -1 : 0);
        ny  = ty + ((d == 2) ? 1 : (d == 0) ? -1 : 0);
        oob = (ny < 0) || (ny >= H);
        if (nx < 0 || nx >= W) begin
`ifdef PACMAN_TUNNEL_EN
            nx = (nx + W) % W;
`else
            oob = 1'b1;
`endif
        end
    endtask

    task automatic schedule_lookup();
        int nx, ny;
        bit oob;
        lkwalls = 0;
        for (int d = 0; d < 4; d++) begin
            neighbour(mx / 16, my / 16, d, nx, ny, oob);
            addr_q.push_back(((ny & 31) << 5) | (nx & 31));
            if (oob || maze[ny][nx]) lkwalls = lkwalls | (1 << d);
        end
        busy   = 5;
        mvalid = 1'b0;
    endtask

    task automatic model_reset();
        mx = SX; my = SY; mwalls = 0; pend = 1'b0;
        schedule_lookup();
        busy = 6;  // one extra cycle spent in INIT
    endtask

    function automatic exp_t cur_exp();
        exp_t e;
        e.x = mx; e.y = my; e.walls = mwalls; e.valid = mvalid;
        e.rd = (busy >= 2 && busy <= 5);
        return e;
    endfunction

    task automatic model_edge(input bit tick, input int dir);
        int d, nx, ny;
        if (busy > 0) begin
            if (tick) pend = 1'b1;
            busy--;
            if (busy == 0) begin
                mwalls = lkwalls;
                mvalid = 1'b1;
            end
        end else if (tick || pend) begin
            pend = 1'b0;
            if (dir >= 4) begin
                d = dir - 4;
                if (!((mx % 16 == 0) && (my % 16 == 0) && mwalls[d])) begin
                    nx = mx + ((d == 1) ? ST : (d == 3) ? -ST : 0);
                    ny = my + ((d == 2) ? ST : (d == 0) ? -ST : 0);
`ifdef PACMAN_TUNNEL_EN
                    if (nx < 0) nx = (W - 1) * 16;
                    else if (d == 1 && mx == (W - 1) * 16) nx = 0;
`endif
                    mx = nx; my = ny;
                    if (mx % 16 == 0 && my % 16 == 0) schedule_lookup();
                end
            end
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge Clk) begin
        if (mon_en) begin
            exp_t e;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL state @%0t: no expected entry queued", $time);
            end else begin
                e = exp_q.pop_front();
                if (pacman_x !== 10'(e.x) || pacman_y !== 10'(e.y) ||
                    adjacent_walls !== 4'(e.walls) || walls_valid !== e.valid ||
                    wall_rd !== e.rd) begin
                    miscompares++;
                    $display("FAIL state @%0t: got x=%0d y=%0d walls=%b valid=%b rd=%b, want x=%0d y=%0d walls=%b valid=%b rd=%b",
                             $time, pacman_x, pacman_y, adjacent_walls, walls_valid, wall_rd,
                             e.x, e.y, 4'(e.walls), e.valid, e.rd);
                end
            end
            if (wall_rd === 1'b1) begin
                vectors++;
                if (addr_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL wall_addr @%0t: got %0d, no read expected", $time, wall_addr);
                end else begin
                    int a;
                    a = addr_q.pop_front();
                    if (wall_addr !== 10'(a)) begin
                        miscompares++;
                        $display("FAIL wall_addr @%0t: got {%0d,%0d}, want {%0d,%0d}",
                                 $time, wall_addr[9:5], wall_addr[4:0], a >> 5, a & 31);
                    end
                end
            end
        end
    end

    // ---------------- driver ----------------
    // Called just after a posedge: release reset mid-cycle and restart the model.
    task automatic release_reset();
        #2;
        Reset_n = 1'b1;
        model_reset();
        exp_q.push_back(cur_exp());
        mon_en = 1'b1;
    endtask

    // Drive one clock: inputs for the next edge, model that edge, wait past it.
    task automatic step(input bit tick, input logic [2:0] dir);
        frame_tick = tick;
        direction  = dir;
        model_edge(tick, int'(dir));
        exp_q.push_back(cur_exp());
        @(posedge Clk);
        #1;
    endtask

    // Abort a lookup in its 3rd cycle; everything must snap to reset values.
    task automatic mid_reset();
        #1;
        Reset_n    = 1'b0;
        frame_tick = 1'b0;
        mon_en     = 1'b0;
        #1;
        vectors++;
        if (pacman_x !== 10'(SX) || pacman_y !== 10'(SY) || adjacent_walls !== 4'd0 ||
            walls_valid !== 1'b0 || wall_rd !== 1'b0 || wall_addr !== 10'd0) begin
            miscompares++;
            $display("FAIL async_reset: got x=%0d y=%0d walls=%b valid=%b rd=%b addr=%0d, want %0d %0d 0000 0 0 0",
                     pacman_x, pacman_y, adjacent_walls, walls_valid, wall_rd, wall_addr, SX, SY);
        end
        exp_q.delete();
        addr_q.delete();
        @(posedge Clk);
        release_reset();
        rst_done = 1'b1;
    endtask

    function automatic int pick_dir();
        return ($urandom_range(0, 9) < 8) ? int'($urandom_range(4, 7)) : int'($urandom_range(0, 3));
    endfunction

    // fdir < 0: random walk with persistent heading; otherwise a fixed heading.
    task automatic run(input int nticks, input int fdir, input int maxgap, input bit allow_rst);
        int cur;
        cur = 5;
        for (int t = 0; t < nticks; t++) begin
            int gap;
            gap = int'($urandom_range(0, maxgap));
            if (fdir < 0 && $urandom_range(0, 15) == 0) cur = pick_dir();
            for (int g = 0; g <= gap; g++) begin
                logic [2:0] d;
                d = (fdir >= 0) ? 3'(fdir) : (g == gap) ? 3'(cur) : 3'($urandom_range(0, 7));
                step(g == gap, d);
                if (allow_rst && !rst_done && busy == 3 && mwalls != 0) mid_reset();
            end
        end
    endtask

    task automatic settle();
        int n;
        n = 0;
        while (busy != 0 && n < 20) begin
            step(1'b0, 3'd0);
            n++;
        end
        vectors++;
        if (busy != 0) begin
            miscompares++;
            $display("FAIL settle: lookup still busy after %0d cycles, want idle", n);
        end
        step(1'b0, 3'd0);
    endtask

    initial begin
        rst_done = 1'b0;
        for (int y = 0; y < 32; y++)
            for (int x = 0; x < 32; x++)
                maze[y][x] = 1'b0;

        repeat (2) @(posedge Clk);
        release_reset();

        // Open maze: drive into all four edges (wrap or stop on the left/right).
        run(300, 7, 3, 1'b0);
        run(400, 4, 3, 1'b0);
        run(500, 5, 3, 1'b0);
        run(600, 6, 3, 1'b0);
        settle();

        // Random maze (~25% walls), random heading, ticks often land in lookups.
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                maze[y][x] = ($urandom_range(0, 3) == 0);
        run(1500, -1, 5, 1'b1);
        settle();
        repeat (8) step(1'b0, 3'd0);

        @(negedge Clk);
        #1;
        mon_en = 1'b0;
        vectors++;
        if (addr_q.size() != 0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d reads and %0d states left unseen, want 0 and 0",
                     addr_q.size(), exp_q.size());
        end
        vectors++;
        if (!rst_done) begin
            miscompares++;
            $display("FAIL mid_lookup_reset: never injected, want injected");
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
